// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned IDX_W          = 16;

    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StCntHi,
        StCntLo,
        StData,
        StWrite,
        StCsum,
        StErr
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and load status of the loader.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic              byte_valid;
    logic [BYTE_W-1:0] byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [WORD_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wd;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wd, cpu_hold, load_done, load_err
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wd, cpu_hold, load_done, load_err
    );

endinterface

// File: rtl/word_packer.sv
// Four-byte MSB-first shift register with byte counter and word-complete flag.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              shift_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic [1:0]        byte_cnt_o,
    output logic              full_o
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              full_q, full_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        if (clr_i) begin
            word_d = '0;
            cnt_d  = '0;
            full_d = 1'b0;
        end else if (shift_i) begin
            word_d = {word_q[WORD_W-BYTE_W-1:0], byte_i};
            cnt_d  = cnt_q + 2'd1;
            full_d = (cnt_q == 2'd3);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign word_o     = word_q;
    assign byte_cnt_o = cnt_q;
    assign full_o     = full_q;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader writing packed words into instruction memory from word 0.
// Optional inter-byte timeout: define IMEM_LOADER_TIMEOUT_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned       DEPTH_WORDS = 256,
    parameter logic [BYTE_W-1:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int unsigned       TIMEOUT_CYC = 100000
) (
    input logic           clk,
    input logic           reset,
    imem_loader_if.master bus
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BYTE_W-1:0]  csum_q, csum_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               hold_q, hold_d;

    logic               byte_ready, xfer, start, csum_ok, timeout_hit;
    logic [IDX_W-1:0]   n_next;
    logic [WORD_W-1:0]  pk_word;
    logic [1:0]         pk_cnt;
    logic               pk_full;

    assign byte_ready = (state_q != StWrite);
    assign xfer       = bus.byte_valid && byte_ready;
    // SYNC_BYTE is only a frame start outside a frame; inside it is plain data.
    assign start      = (state_q == StIdle || state_q == StErr) && xfer &&
                        (bus.byte_data == SYNC_BYTE);
    assign csum_ok    = (state_q == StCsum) && xfer && (bus.byte_data == csum_q);
    assign n_next     = {cnt_q[IDX_W-1:BYTE_W], bus.byte_data};

    word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (start),
        .shift_i    ((state_q == StData) && xfer),
        .byte_i     (bus.byte_data),
        .word_o     (pk_word),
        .byte_cnt_o (pk_cnt),
        .full_o     (pk_full)
    );

`ifdef IMEM_LOADER_TIMEOUT_EN
    logic [31:0] to_q, to_d;
    logic        timed;

    assign timed       = (state_q == StCntHi) || (state_q == StCntLo) ||
                         (state_q == StData)  || (state_q == StCsum);
    assign timeout_hit = timed && !xfer && (to_q == TIMEOUT_CYC - 32'd1);

    always_comb begin
        to_d = to_q + 32'd1;
        if (!timed || xfer) to_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) to_q <= '0;
        else        to_q <= to_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            done_q  <= done_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StErr: begin
                if (start)                 state_d = StCntHi;
                else if (state_q == StErr) state_d = StIdle;
            end
            StCntHi: if (xfer) state_d = StCntLo;
            StCntLo: begin
                if (xfer) begin
                    if (32'(n_next) > DEPTH_WORDS) state_d = StErr;
                    else if (n_next == '0)         state_d = StCsum;
                    else                           state_d = StData;
                end
            end
            StData:  if (xfer && pk_cnt == 2'd3) state_d = StWrite;
            StWrite: state_d = (idx_q + 16'd1 == cnt_q) ? StCsum : StData;
            StCsum:  if (xfer) state_d = csum_ok ? StIdle : StErr;
            default: state_d = StIdle;
        endcase
        if (timeout_hit) state_d = StErr;
    end

    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        csum_d = csum_q;
        done_d = done_q;
        err_d  = err_q;
        hold_d = hold_q;
        if (start) begin
            idx_d  = '0;
            csum_d = '0;
            done_d = 1'b0;
            err_d  = 1'b0;
            hold_d = 1'b1;
        end
        if (xfer && (state_q == StCntHi || state_q == StCntLo || state_q == StData)) begin
            csum_d = csum_q ^ bus.byte_data;
        end
        if (xfer && state_q == StCntHi) cnt_d[IDX_W-1:BYTE_W] = bus.byte_data;
        if (xfer && state_q == StCntLo) cnt_d[BYTE_W-1:0]     = bus.byte_data;
        if (state_q == StWrite)         idx_d = idx_q + 16'd1;
        if (csum_ok) begin
            done_d = 1'b1;
            hold_d = 1'b0;
        end
        if (state_d == StErr) err_d = 1'b1;
    end

    always_comb begin
        bus.byte_ready = byte_ready;
        bus.imem_we    = (state_q == StWrite) && pk_full;
        bus.imem_addr  = {14'd0, idx_q, 2'b00};
        bus.imem_wd    = pk_word;
        bus.cpu_hold   = hold_q;
        bus.load_done  = done_q;
        bus.load_err   = err_q;
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; honours IMEM_LOADER_TIMEOUT_EN.
module tb_imem_loader;
    import imem_loader_pkg::*;

`ifdef IMEM_LOADER_TIMEOUT_EN
    localparam int unsigned TO = 16;
`else
    localparam int unsigned TO = 100000;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   wr_cnt = 0;

    imem_loader_if bus ();

    imem_loader #(
        .DEPTH_WORDS (256),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // byte_ready may only drop during the single write cycle
    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("ready_bubble", 32'(bus.byte_ready), 32'(!bus.imem_we));
            if (bus.imem_we) wr_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        n = 0;
        while (!bus.byte_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n >= 8) check_eq("ready_stuck", 32'(bus.byte_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input int gapmax);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], $urandom_range(0, gapmax));
        check_eq("we_latency", 32'(bus.imem_we), 32'd1);
        check_eq("wr_addr", bus.imem_addr, addr);
        check_eq("wr_data", bus.imem_wd, w);
    endtask

    task automatic check_status(input string tag, input logic done, input logic err,
                                input logic hold);
        check_eq({tag, "_done"}, 32'(bus.load_done), 32'(done));
        check_eq({tag, "_err"}, 32'(bus.load_err), 32'(err));
        check_eq({tag, "_hold"}, 32'(bus.cpu_hold), 32'(hold));
    endtask

    initial begin
        #100000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        #23;
        check_eq("rst_ready", 32'(bus.byte_ready), 32'd1);
        check_eq("rst_we", 32'(bus.imem_we), 32'd0);
        check_eq("rst_addr", bus.imem_addr, 32'd0);
        check_eq("rst_wd", bus.imem_wd, 32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Good two-word frame, checksum 0x02
        wr_cnt = 0;
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_word(32'h12345678, 32'h0, 0);
        send_word(32'h9ABCDEF0, 32'h4, 0);
        send_byte(8'h02, 0);
        check_status("good", 1'b1, 1'b0, 1'b0);
        check_eq("good_wrcnt", 32'(wr_cnt), 32'd2);

        // Same frame, bad checksum
        wr_cnt = 0;
        send_byte(8'hA5, 0);
        check_status("sync_clr", 1'b0, 1'b0, 1'b1);
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_word(32'h12345678, 32'h0, 0);
        send_word(32'h9ABCDEF0, 32'h4, 0);
        send_byte(8'hFD, 0);
        check_status("badcs", 1'b0, 1'b1, 1'b1);
        check_eq("badcs_wrcnt", 32'(wr_cnt), 32'd2);

        // Oversize count 257
        wr_cnt = 0;
        send_byte(8'hA5, 0);
        check_eq("ovf_sync_clr_err", 32'(bus.load_err), 32'd0);
        send_byte(8'h01, 0); send_byte(8'h01, 0);
        check_status("ovf", 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check_eq("ovf_sticky", 32'(bus.load_err), 32'd1);
        check_eq("ovf_wrcnt", 32'(wr_cnt), 32'd0);

        // Count 256 is legal; abort it with reset after one word
        send_byte(8'hA5, 0);
        check_eq("ovf_next_sync", 32'(bus.load_err), 32'd0);
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        check_eq("max_no_err", 32'(bus.load_err), 32'd0);
        send_word(32'hCAFEF00D, 32'h0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_status("midrst", 1'b0, 1'b0, 1'b1);
        check_eq("midrst_ready", 32'(bus.byte_ready), 32'd1);
        check_eq("midrst_addr", bus.imem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Empty frame
        wr_cnt = 0;
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        check_status("empty", 1'b1, 1'b0, 1'b0);
        check_eq("empty_wrcnt", 32'(wr_cnt), 32'd0);

        // Garbage before sync, random valid gaps, A5 inside data
        send_byte(8'h00, 0); send_byte(8'hFF, 1); send_byte(8'h13, 2);
        check_status("garbage", 1'b1, 1'b0, 1'b0);
        wr_cnt = 0;
        send_byte(8'hA5, 1); send_byte(8'h00, 2); send_byte(8'h01, 1);
        send_word(32'hDEADBEEF, 32'h0, 3);
        send_byte(8'h23, 2);
        check_status("gaps", 1'b1, 1'b0, 1'b0);
        check_eq("gaps_wrcnt", 32'(wr_cnt), 32'd1);
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_word(32'hA5A5A5A5, 32'h0, 0);
        send_byte(8'h01, 0);
        check_status("sync_as_data", 1'b1, 1'b0, 1'b0);

        // Stall after count bytes
        wr_cnt = 0;
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
        repeat (40) @(negedge clk);
`ifdef IMEM_LOADER_TIMEOUT_EN
        check_status("timeout", 1'b0, 1'b1, 1'b1);
        check_eq("timeout_wrcnt", 32'(wr_cnt), 32'd0);
`else
        check_status("stall", 1'b0, 1'b0, 1'b1);
        send_word(32'h11223344, 32'h0, 0);
        send_byte(8'h45, 0);
        check_status("resume", 1'b1, 1'b0, 1'b0);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
